// File: rtl/fifo_bit_serializer.sv
// Pops words from a fifo_v3-style queue and streams them LSB first on a valid/ready bit stream.
// Define FIFO_BIT_SERIALIZER_PARITY_EN to append an even-parity beat after the last data bit.
module fifo_bit_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  bit_o,
    output logic                  bit_valid_o,
    input  logic                  bit_ready_i,
    output logic                  last_o,
    output logic                  busy_o
);

`ifdef FIFO_BIT_SERIALIZER_PARITY_EN
    localparam int NBEATS = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] PARITY_CNT = CNT_WIDTH'(DATA_WIDTH);
`else
    localparam int NBEATS = DATA_WIDTH;
`endif
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NBEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic                  in_shift;
    logic                  final_beat;
    logic                  load;

`ifdef FIFO_BIT_SERIALIZER_PARITY_EN
    logic parity_q, parity_d;
`endif

    assign in_shift   = (state_q == SHIFT);
    assign final_beat = in_shift && (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
`ifdef FIFO_BIT_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        if (flush_i) begin
            // Flush wins over any handshake or pop in the same cycle.
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
`ifdef FIFO_BIT_SERIALIZER_PARITY_EN
            parity_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_i) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_ready_i) begin
                        if (cnt_q == LAST_CNT) begin
                            if (!fifo_empty_i) begin
                                load = 1'b1;
                            end else begin
                                state_d = IDLE;
                                shreg_d = '0;
                                cnt_d   = '0;
                            end
                        end else begin
                            shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                            cnt_d   = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A reload on the final beat keeps the stream bubble-free.
        if (load) begin
            shreg_d = fifo_data_i;
            cnt_d   = '0;
`ifdef FIFO_BIT_SERIALIZER_PARITY_EN
            parity_d = ^fifo_data_i;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FIFO_BIT_SERIALIZER_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bit_o = in_shift && ((cnt_q == PARITY_CNT) ? parity_q : shreg_q[0]);
`else
    assign bit_o = in_shift && shreg_q[0];
`endif

    // The IDLE pop is combinational, so it is masked while reset is held.
    assign fifo_pop_o  = load && rst_ni;
    assign bit_valid_o = in_shift;
    assign busy_o      = in_shift;
    assign last_o      = final_beat;

    a_no_pop_when_empty: assert property (
        @(posedge clk_i) disable iff (!rst_ni) fifo_pop_o |-> !fifo_empty_i
    );

    a_stable_under_backpressure: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (bit_valid_o && !bit_ready_i && !flush_i) |=> (bit_valid_o && $stable(bit_o) && $stable(last_o))
    );

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// Randomised scoreboard bench for fifo_bit_serializer with a queue-based FIFO and word-level reference model.
module tb_fifo_bit_serializer;

    localparam int DW = 32;
`ifdef FIFO_BIT_SERIALIZER_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    typedef struct {
        logic b;
        logic last;
    } beat_t;

    logic          clk_i;
    logic          rst_ni;
    logic          flush_i;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_pop_o;
    logic          bit_o;
    logic          bit_valid_o;
    logic          bit_ready_i;
    logic          last_o;
    logic          busy_o;

    logic [DW-1:0] fifoQ[$];
    beat_t         expQ[$];
    logic          expValid;
    int            compareCount;
    int            mismatchCount;
    int            hsCount;

    fifo_bit_serializer #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_pop_o  (fifo_pop_o),
        .bit_o       (bit_o),
        .bit_valid_o (bit_valid_o),
        .bit_ready_i (bit_ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic actual, input logic required);
        compareCount++;
        if (actual !== required) begin
            mismatchCount++;
            $display("[TB] FAIL %s actual=%0b required=%0b at %0t", name, actual, required, $time);
        end
    endtask

    // A queued word becomes NB expected beats, LSB first, plus parity when enabled.
    task automatic pushWord(input logic [DW-1:0] w);
        fifoQ.push_back(w);
        for (int i = 0; i < DW; i++) begin
            expQ.push_back('{b: w[i], last: (i == NB - 1)});
        end
        if (NB > DW) begin
            expQ.push_back('{b: ^w, last: 1'b1});
        end
    endtask

    task automatic dropInflight();
        beat_t d;
        while (expQ.size() > 0) begin
            d = expQ.pop_front();
            if (d.last) break;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ready, input logic flush);
        @(negedge clk_i);
        rst_ni       = rst;
        bit_ready_i  = ready;
        flush_i      = flush;
        fifo_empty_i = (fifoQ.size() == 0);
        fifo_data_i  = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    endtask

    // Monitor: samples mid-low-phase and compares against the word-level model.
    initial begin
        logic expLast;
        logic expPop;
        logic nextValid;
        expValid = 1'b0;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_ni) begin
                checkOutput("rst_pop",   fifo_pop_o,  1'b0);
                checkOutput("rst_valid", bit_valid_o, 1'b0);
                checkOutput("rst_bit",   bit_o,       1'b0);
                checkOutput("rst_last",  last_o,      1'b0);
                checkOutput("rst_busy",  busy_o,      1'b0);
                if (expValid) dropInflight();
                expValid = 1'b0;
            end else begin
                expLast = expValid && (expQ.size() > 0) && expQ[0].last;
                expPop  = !flush_i && !fifo_empty_i && (!expValid || (bit_ready_i && expLast));
                checkOutput("bit_valid", bit_valid_o, expValid);
                checkOutput("busy",      busy_o,      expValid);
                checkOutput("last",      last_o,      expLast);
                checkOutput("pop",       fifo_pop_o,  expPop);
                if (expValid && expQ.size() > 0) begin
                    checkOutput("bit", bit_o, expQ[0].b);
                end
                if (expValid && flush_i) begin
                    dropInflight();
                end else if (expValid && bit_ready_i && expQ.size() > 0) begin
                    void'(expQ.pop_front());
                    hsCount++;
                end
                nextValid = !flush_i && (expPop || (expValid && !(bit_ready_i && expLast)));
                if (expPop) void'(fifoQ.pop_front());
                expValid = nextValid;
            end
        end
    end

    initial begin
        int hsBefore;
        int guard;
        compareCount  = 0;
        mismatchCount = 0;
        hsCount       = 0;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        bit_ready_i   = 1'b0;
        fifo_empty_i  = 1'b1;
        fifo_data_i   = '0;

        // Reset held with a non-empty queue: no pop may leak out.
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushWord(32'h0000_00A5);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

        // Single word.
        hsBefore = hsCount;
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("single_beats", (hsCount - hsBefore) == NB, 1'b1);

        // Back-to-back words, no bubble.
        pushWord(32'hFFFF_FFFF);
        pushWord(32'h0000_0001);
        hsBefore = hsCount;
        repeat (2 * NB + 6) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("b2b_beats", (hsCount - hsBefore) == 2 * NB, 1'b1);

        // Backpressure 1,0,0 repeating.
        pushWord(32'h8000_0000);
        hsBefore = hsCount;
        for (int i = 0; i < 3 * NB + 6; i++) applyStimulus(1'b1, (i % 3) == 0, 1'b0);
        checkOutput("bp_beats", (hsCount - hsBefore) == NB, 1'b1);

        // Flush at beat 10 with a second word waiting.
        pushWord(32'h1234_5678);
        pushWord(32'hCAFE_F00D);
        repeat (11) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (NB + 4) applyStimulus(1'b1, 1'b1, 1'b0);

        // Reset at beat 5, then a fresh word.
        pushWord(32'hDEAD_BEEF);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
        pushWord(32'h0F0F_5A5A);
        repeat (NB + 4) applyStimulus(1'b1, 1'b1, 1'b0);

        // Parity-sensitive words (odd and even popcount).
        pushWord(32'h0000_0007);
        pushWord(32'h0000_0003);
        repeat (2 * NB + 4) applyStimulus(1'b1, 1'b1, 1'b0);

        // Random traffic with stalls, flushes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0 && fifoQ.size() < 4) pushWord($urandom());
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
        end

        guard = 0;
        while ((expQ.size() > 0 || fifoQ.size() > 0 || expValid) && guard < 2000) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            guard++;
        end
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("drained", (expQ.size() == 0) && (fifoQ.size() == 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
